// File: rtl/pc_redirect_arbiter.sv
// Fixed-priority redirect scheduler (ROB > predecode > BTB) with a one-entry hold
// register that parks the winner across fetch stalls. Optional epoch counter: PC_REDIR_EPOCH_EN.
module pc_redirect_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int EPOCH_W = 3
) (
  input  logic               Clk,
  input  logic               Rest,
  input  logic               IcacheBusy,
  input  logic               CtrlStop,
  input  logic               BtbPredictAble,
  input  logic [ADDR_W-1:0]  BtbPreDictPc,
  input  logic               PreReDirAble,
  input  logic [ADDR_W-1:0]  PreReDirPc,
  input  logic               RobReDirAble,
  input  logic [ADDR_W-1:0]  RobReDirPc,
  output logic               PcStop,
  output logic               RedirAble,
  output logic [ADDR_W-1:0]  RedirPc,
  output logic               FlushFetch,
  output logic               FlushDecode,
  output logic               PendValid,
  output logic [EPOCH_W-1:0] FetchEpoch
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [1:0]          pend_rank_q, pend_rank_d;
  logic [ADDR_W-1:0]   pend_pc_q, pend_pc_d;
  logic                redir_able_q, redir_able_d;
  logic [ADDR_W-1:0]   redir_pc_q, redir_pc_d;
  logic                flush_fetch_q, flush_fetch_d;
  logic                flush_decode_q, flush_decode_d;

  logic                stall;
  logic [1:0]          rank_new;
  logic [ADDR_W-1:0]   pc_new;
  logic                take_new;
  logic                cand_valid;
  logic [1:0]          cand_rank;
  logic [ADDR_W-1:0]   cand_pc;

  assign stall  = IcacheBusy | CtrlStop;
  assign PcStop = stall;

  always_comb begin
    rank_new = 2'd0;
    pc_new   = '0;
    if (RobReDirAble) begin
      rank_new = 2'd3;
      pc_new   = RobReDirPc;
    end else if (PreReDirAble) begin
      rank_new = 2'd2;
      pc_new   = PreReDirPc;
    end else if (BtbPredictAble) begin
      rank_new = 2'd1;
      pc_new   = BtbPreDictPc;
    end
  end

  // Equal rank favours the new request: the younger redirect supersedes the parked one.
  assign take_new   = (rank_new != 2'd0) && (rank_new >= pend_rank_q);
  assign cand_valid = take_new || (pend_rank_q != 2'd0);
  assign cand_rank  = take_new ? rank_new : pend_rank_q;
  assign cand_pc    = take_new ? pc_new : pend_pc_q;

  always_comb begin
    state_d        = state_q;
    pend_rank_d    = pend_rank_q;
    pend_pc_d      = pend_pc_q;
    redir_able_d   = 1'b0;
    redir_pc_d     = redir_pc_q;
    flush_fetch_d  = take_new && rank_new[1];
    flush_decode_d = take_new && (rank_new == 2'd3);
    if (cand_valid) begin
      if (stall) begin
        pend_rank_d = cand_rank;
        pend_pc_d   = cand_pc;
        state_d     = HOLD;
      end else begin
        redir_able_d = 1'b1;
        redir_pc_d   = cand_pc;
        pend_rank_d  = 2'd0;
        state_d      = IDLE;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rest) begin
      state_q        <= IDLE;
      pend_rank_q    <= 2'd0;
      pend_pc_q      <= '0;
      redir_able_q   <= 1'b0;
      redir_pc_q     <= '0;
      flush_fetch_q  <= 1'b0;
      flush_decode_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pend_rank_q    <= pend_rank_d;
      pend_pc_q      <= pend_pc_d;
      redir_able_q   <= redir_able_d;
      redir_pc_q     <= redir_pc_d;
      flush_fetch_q  <= flush_fetch_d;
      flush_decode_q <= flush_decode_d;
    end
  end

  assign RedirAble   = redir_able_q;
  assign RedirPc     = redir_pc_q;
  assign FlushFetch  = flush_fetch_q;
  assign FlushDecode = flush_decode_q;
  assign PendValid   = (state_q == HOLD);

`ifdef PC_REDIR_EPOCH_EN
  logic [EPOCH_W-1:0] epoch_q;

  // Advances on the same edge that registers the fetch flush, so tag and flush line up.
  always_ff @(posedge Clk) begin
    if (Rest) begin
      epoch_q <= '0;
    end else if (flush_fetch_d) begin
      epoch_q <= epoch_q + EPOCH_W'(1);
    end
  end

  assign FetchEpoch = epoch_q;
`else
  assign FetchEpoch = '0;
`endif

endmodule

// File: doc/pc_redirect_arbiter.md
# pc_redirect_arbiter

Front-end redirect scheduler sitting in front of the PC register in the BPU. It collects redirect requests from three sources: BTB prediction, predecode correction and ROB commit-time redirect. Each cycle it selects one by fixed priority and holds it across fetch stalls so that no redirect is lost. It drives a single registered redirect port and a stop line into the PC, and emits front-end flush pulses and a fetch epoch.

## Interface
- ADDR_W, 32, instruction address width (matches `InstAddrBus`)
- EPOCH_W, 3, fetch epoch counter width
- Clk  in  1  core clock
- Rest  in  1  reset; one clock; reset is synchronous and active-high
- IcacheBusy  in  1  ICache cannot accept a new fetch address this cycle
- CtrlStop  in  1  pipeline control stall request
- BtbPredictAble  in  1  BTB prediction valid
- BtbPreDictPc  in  ADDR_W  predicted target
- PreReDirAble  in  1  predecode redirect valid
- PreReDirPc  in  ADDR_W  predecode target
- RobReDirAble  in  1  ROB redirect valid (mispredict/exception)
- RobReDirPc  in  ADDR_W  ROB target
- PcStop  out  1  hold PC; combinational = IcacheBusy | CtrlStop
- RedirAble  out  1  registered redirect valid to PC
- RedirPc  out  ADDR_W  registered redirect target
- FlushFetch  out  1  one-cycle pulse: kill IF/predecode contents
- FlushDecode  out  1  one-cycle pulse: kill decode contents
- PendValid  out  1  a redirect is parked in the hold register
- FetchEpoch  out  EPOCH_W  current fetch epoch (macro-dependent, see Configuration)

## Operation
- Rank: ROB = 3, Pre = 2, BTB = 1, none = 0. The new-request winner is the highest-rank valid input this cycle. Lower-rank inputs in the same cycle are dropped.
- Hold register {PendRank[1:0], PendPc}. FSM has two states: IDLE (PendRank = 0) and HOLD (PendRank != 0). PendValid = (state == HOLD).
- Candidate: the new winner if rank_new >= PendRank, else the pending entry. Equal rank goes to the new request, because the younger redirect supersedes.
- Stall = IcacheBusy | CtrlStop.
- Not stall with a candidate: RedirAble <= 1, RedirPc <= candidate PC, PendRank <= 0, state goes to IDLE.
- Not stall with no candidate: RedirAble <= 0.
- Stall with a candidate: RedirAble <= 0, hold register <= candidate, state goes to HOLD. RedirPc keeps its last value.
- Flush is computed on acceptance of a new request, not on issue, so it also fires while stalled:
  - FlushFetch <= 1 if the new winner is ROB or Pre and rank_new >= PendRank.
  - FlushDecode <= 1 only if the new winner is ROB.
  - Both are 0 otherwise.
- A BTB request never flushes.
- A pending ROB entry blocks later Pre and BTB entries. A pending Pre entry blocks later BTB entries.

## Timing
- Reset values: RedirAble 0, RedirPc 0, FlushFetch 0, FlushDecode 0, PendValid 0, FetchEpoch 0, state IDLE. PcStop follows its inputs even during reset.
- Reset mid-HOLD discards the pending redirect. No redirect is issued after reset is released.
- Latency from request to RedirAble is 1 cycle when no stall is present. Under stall, RedirAble rises 1 cycle after the first non-stall cycle.
- RedirAble is a single-cycle pulse per accepted candidate. Back-to-back requests in consecutive non-stall cycles produce consecutive pulses.
- Flush pulses go high 1 cycle after the accepting edge and are independent of stall.
- Width rules:
  - PendRank is 2 bits.
  - Epoch wraps modulo 2^EPOCH_W, so 7 + 1 = 0 for EPOCH_W = 3.

## Configuration
- PC_REDIR_EPOCH_EN defined:
  - FetchEpoch increments by 1 on every cycle in which FlushFetch is set, registered together with the flush pulse.
  - Tagged fetches whose epoch mismatches are discarded downstream.
- Not defined:
  - FetchEpoch is tied to 0.
  - The counter logic is absent.
  - Flush pulses are unchanged.

## Test plan
- Reset release, all inputs 0 for 5 cycles -> RedirAble, flushes and PendValid stay 0; FetchEpoch = 0.
- Same cycle: BtbPredictAble, BtbPreDictPc=0x1c000040, RobReDirAble, RobReDirPc=0x1c000100, no stall -> next cycle RedirAble=1, RedirPc=0x1c000100, FlushFetch=1, FlushDecode=1; BTB target is never issued.
- IcacheBusy=1 for 4 cycles; Pre redirect 0x1c000200 in cycle 1, BTB 0x1c000300 in cycle 2 -> PendValid=1, hold keeps 0x1c000200, FlushFetch pulses once in cycle 2; the cycle after busy drops RedirAble=1, RedirPc=0x1c000200, PendValid=0.
- Under stall: pending Pre 0x1c000200, then ROB 0x1c000500 arrives -> hold replaced, FlushDecode pulses; release issues 0x1c000500 only.
- Rest asserted while PendValid=1 -> next cycle PendValid=0; after release no RedirAble pulse.
- With PC_REDIR_EPOCH_EN: 9 ROB redirects on consecutive cycles -> FetchEpoch goes 1..7, 0, 1; without the macro FetchEpoch stays 0.
